// File: rtl/uart_rx_pkg.sv
// Shared constants and the effective-sample-count helper for the UART RX oversampler.
package uart_rx_pkg;

    localparam logic [1:0] SMP_1 = 2'd0;
    localparam logic [1:0] SMP_3 = 2'd1;
    localparam logic [1:0] SMP_5 = 2'd2;

    localparam int PRESCALE_MIN = 4;
    localparam int MIN_P_3      = 6;
    localparam int MIN_P_5      = 8;

    // Short bit periods cannot fit a wide vote window before the decision edge.
    function automatic logic [2:0] eff_samples(input int unsigned p, input logic [1:0] mode);
        logic [2:0] n;
        case (mode)
            SMP_1:   n = 3'd1;
            SMP_3:   n = 3'd3;
            default: n = 3'd5;
        endcase
        if (n == 3'd5 && p < MIN_P_5) n = 3'd3;
        if (n == 3'd3 && p < MIN_P_3) n = 3'd1;
        return n;
    endfunction

endpackage

// File: rtl/uart_rx_edge_counter.sv
// Bit-period edge counter with shadowed prescale/mode captured at each bit boundary.
module uart_rx_edge_counter
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [1:0]            sample_mode,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [PRESCALE_W-1:0] p_shadow,
    output logic [1:0]            mode_shadow,
    output logic                  last
);

    logic [PRESCALE_W-1:0] cnt_reg, cnt_next;
    logic [PRESCALE_W-1:0] p_reg;
    logic [1:0]            mode_reg;
    logic [PRESCALE_W-1:0] prescale_clamped;
    logic [1:0]            mode_clamped;

    assign last = en && (cnt_reg == p_reg - 1'b1);

    always_comb begin
        cnt_next = '0;
        if (en && !last) cnt_next = cnt_reg + 1'b1;
    end

    assign prescale_clamped = (prescale < PRESCALE_W'(PRESCALE_MIN)) ? PRESCALE_W'(PRESCALE_MIN) : prescale;
    assign mode_clamped     = (sample_mode == 2'd3) ? SMP_5 : sample_mode;

    // The shadow follows the inputs whenever the next count is 0, so it is frozen for a whole bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_reg  <= '0;
            p_reg    <= PRESCALE_W'(PRESCALE_MIN);
            mode_reg <= SMP_1;
        end else begin
            cnt_reg <= cnt_next;
            if (cnt_next == '0) begin
                p_reg    <= prescale_clamped;
                mode_reg <= mode_clamped;
            end
        end
    end

    assign edge_cnt    = cnt_reg;
    assign p_shadow    = p_reg;
    assign mode_shadow = mode_reg;

endmodule

// File: rtl/uart_rx_oversampler.sv
// UART RX data sampler: centred 1/3/5-sample majority vote with valid strobe and noise flag.
module uart_rx_oversampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [1:0]            sample_mode,
    input  logic                  data_sample_en,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic                  sampled_bit,
    output logic                  sample_valid,
    output logic                  noise_flag
);

    logic [PRESCALE_W-1:0] p_shadow;
    logic [1:0]            mode_shadow;
    logic                  last;
    logic [2:0]            n_eff;
    logic [2:0]            half;
    logic [PRESCALE_W:0]   cnt_plus2;
    logic [4:0]            hit;
    logic                  sample_now;
    logic [2:0]            ones_reg;
    logic                  saw0_reg;
    logic                  saw1_reg;

    uart_rx_edge_counter #(
        .PRESCALE_W (PRESCALE_W)
    ) u_edge_counter (
        .clk         (clk),
        .rst         (rst),
        .en          (data_sample_en),
        .prescale    (prescale),
        .sample_mode (sample_mode),
        .edge_cnt    (edge_cnt),
        .p_shadow    (p_shadow),
        .mode_shadow (mode_shadow),
        .last        (last)
    );

    assign n_eff     = eff_samples(32'(p_shadow), mode_shadow);
    assign half      = n_eff >> 1;
    assign cnt_plus2 = {1'b0, edge_cnt} + (PRESCALE_W+1)'(2);

    // Slot gi sits at offset gi-2 from the centre; biasing both sides by 2 avoids negative positions.
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_slot
            localparam int OFF = (gi > 2) ? (gi - 2) : (2 - gi);
            assign hit[gi] = (3'(OFF) <= half) &&
                             (cnt_plus2 == ({1'b0, p_shadow >> 1} + (PRESCALE_W+1)'(gi)));
        end
    endgenerate

    assign sample_now = data_sample_en && (|hit);

    always_ff @(posedge clk) begin
        if (!rst) begin
            ones_reg     <= '0;
            saw0_reg     <= 1'b0;
            saw1_reg     <= 1'b0;
            sampled_bit  <= 1'b1;
            sample_valid <= 1'b0;
            noise_flag   <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (!data_sample_en) begin
                ones_reg <= '0;
                saw0_reg <= 1'b0;
                saw1_reg <= 1'b0;
            end else if (last) begin
                sampled_bit  <= (ones_reg > half);
                sample_valid <= 1'b1;
                noise_flag   <= saw0_reg & saw1_reg;
                ones_reg     <= '0;
                saw0_reg     <= 1'b0;
                saw1_reg     <= 1'b0;
            end else if (sample_now) begin
                ones_reg <= ones_reg + {2'b00, RX_IN};
                if (RX_IN) saw1_reg <= 1'b1;
                else       saw0_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Scoreboard bench for uart_rx_oversampler: per-bit expectations queued at drive time, checked on strobe.
module tb_uart_rx_oversampler;

    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          RX_IN;
    logic [PW-1:0] prescale;
    logic [1:0]    sample_mode;
    logic          data_sample_en;
    logic [PW-1:0] edge_cnt;
    logic          sampled_bit;
    logic          sample_valid;
    logic          noise_flag;

    uart_rx_oversampler #(
        .PRESCALE_W (PW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .RX_IN          (RX_IN),
        .prescale       (prescale),
        .sample_mode    (sample_mode),
        .data_sample_en (data_sample_en),
        .edge_cnt       (edge_cnt),
        .sampled_bit    (sampled_bit),
        .sample_valid   (sample_valid),
        .noise_flag     (noise_flag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic bit_v;
        logic noise;
        int   due;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp_v, cyc);
        end
    endtask

    // Reference vote: clamp P and mode, fall back on short periods, count ones in the centred window.
    function automatic void model_bit(input int p_req, input int mode_req, input logic [63:0] line,
                                      output logic b, output logic nz);
        int p, m, n, c, ones;
        p = (p_req < 4) ? 4 : p_req;
        m = (mode_req == 3) ? 2 : mode_req;
        n = (m == 0) ? 1 : ((m == 1) ? 3 : 5);
        if (n == 5 && p < 8) n = 3;
        if (n == 3 && p < 6) n = 1;
        c = p / 2;
        ones = 0;
        for (int k = c - n / 2; k <= c + n / 2; k++) ones += int'(line[k]);
        b  = (ones > n / 2);
        nz = (ones != 0) && (ones != n);
    endfunction

    always @(negedge clk) begin
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            mon_e = sb_q.pop_front();
            check_eq("strobe", 32'(sample_valid), 32'd1);
            check_eq("bit", 32'(sampled_bit), 32'(mon_e.bit_v));
            check_eq("noise", 32'(noise_flag), 32'(mon_e.noise));
            $display("cycle %0d: strobe=%0b bit=%0b (exp %0b) noise=%0b (exp %0b)",
                     cyc, sample_valid, sampled_bit, mon_e.bit_v, noise_flag, mon_e.noise);
        end else if (sample_valid) begin
            check_eq("spurious_strobe", 32'(sample_valid), 32'd0);
        end
    end

    // Load config with one disabled cycle so the shadow captures it, then enable.
    task automatic start_cfg(input int p, input int mode);
        prescale       = PW'(p);
        sample_mode    = 2'(mode);
        data_sample_en = 1'b0;
        RX_IN          = 1'b1;
        @(posedge clk); #1;
        data_sample_en = 1'b1;
    endtask

    task automatic run_bit(input int p, input int mode, input logic [63:0] line,
                           input int chg_pos, input int chg_val);
        logic b, nz;
        model_bit(p, mode, line, b, nz);
        sb_q.push_back('{b, nz, cyc + p});
        for (int i = 0; i < p; i++) begin
            check_eq("edge_cnt", 32'(edge_cnt), 32'(i));
            if (i == chg_pos) prescale = PW'(chg_val);
            RX_IN = line[i];
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b0; RX_IN = 1'b1; prescale = PW'(16); sample_mode = 2'd0; data_sample_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_edge_cnt", 32'(edge_cnt), 32'd0);
        check_eq("rst_bit", 32'(sampled_bit), 32'd1);
        check_eq("rst_valid", 32'(sample_valid), 32'd0);
        check_eq("rst_noise", 32'(noise_flag), 32'd0);
        rst = 1'b1;

        // P=16, 3 samples at 7,8,9; only 8 is high
        start_cfg(16, 1);
        run_bit(16, 1, 64'h100, -1, 0);

        // P=8, 5 samples at 2..6 reading 0,0,1,1,0
        start_cfg(8, 2);
        run_bit(8, 2, 64'hB3, -1, 0);

        // Abort by dropping enable mid-bit with the line high: no strobe, bit held at 0
        start_cfg(16, 0);
        RX_IN = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        data_sample_en = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_eq("abort_hold_bit", 32'(sampled_bit), 32'd0);
        check_eq("abort_cnt", 32'(edge_cnt), 32'd0);

        // Reset at edge_cnt=9 of a P=16 bit
        start_cfg(16, 1);
        RX_IN = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check_eq("pre_rst_cnt", 32'(edge_cnt), 32'd9);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("midrst_cnt", 32'(edge_cnt), 32'd0);
        check_eq("midrst_bit", 32'(sampled_bit), 32'd1);
        check_eq("midrst_valid", 32'(sample_valid), 32'd0);
        rst = 1'b1;
        data_sample_en = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        // P=5 with mode 5 requested collapses to a single sample at 2
        start_cfg(5, 2);
        run_bit(5, 2, 64'h4, -1, 0);
        run_bit(5, 2, ~64'h4, -1, 0);
        run_bit(5, 2, 64'h4, -1, 0);

        // prescale 2 clamps to 4, mode 3 clamps to 5 and falls back to 1 sample
        start_cfg(2, 3);
        run_bit(4, 3, 64'h4, -1, 0);
        run_bit(4, 3, 64'hB, -1, 0);

        // Prescale change mid-bit only affects the following bit
        start_cfg(16, 0);
        run_bit(16, 0, 64'h100, 5, 32);
        run_bit(32, 0, 64'hFFFF_FFFF_FFFE_FFFF, -1, 0);

        // Ten back-to-back bits, P=32, alternating 0/1
        start_cfg(32, 1);
        for (int j = 0; j < 10; j++) begin
            if (j % 2 == 1) run_bit(32, 1, {64{1'b1}}, -1, 0);
            else            run_bit(32, 1, 64'h0, -1, 0);
        end

        data_sample_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("queue_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
